// File: rtl/rv_wb_arb.sv
// rv_wb_arb: writeback arbiter merging ALU and LSU results into one registered RF write.
// Latency: ALU 1 cycle; LSU 1 cycle via bypass (RV_WB_BYPASS_EN defined), otherwise >= 2 through the FIFO.
// Backpressure: ALU never stalls; LSU stalls (lsu_rdy_o low) only while the DEPTH-entry FIFO is full.
// Optional feature macro: RV_WB_BYPASS_EN (LSU-to-output bypass when FIFO empty and no ALU write).
module rv_wb_arb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_vld_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [63:0] alu_data_i,
  input  logic        lsu_vld_i,
  output logic        lsu_rdy_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [63:0] lsu_data_i,
  output logic        wr_en_o,
  output logic [4:0]  wr_reg_o,
  output logic [63:0] wr_data_o,
  output logic [31:0] pend_vec_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_ent_t;

  // FIFO state
  wb_ent_t         r_fifo [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // Output register
  logic            r_wr_en;
  logic [4:0]      r_wr_reg;
  logic [63:0]     r_wr_data;

  // Per-cycle decisions
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_lsu_hs;
  logic            w_lsu_wr;
  logic            w_alu_wr;
  logic            w_pop;
  logic            w_byp;
  logic            w_push;
  wb_ent_t         w_head;
  logic [31:0]     w_pend_vec;

  assign w_fifo_full  = (r_count == CW'(DEPTH));
  assign w_fifo_empty = (r_count == '0);

  // Ready depends only on registered occupancy, never on this cycle's inputs.
  assign lsu_rdy_o = ~w_fifo_full;

  assign w_lsu_hs = lsu_vld_i & lsu_rdy_o;
  // x0 results are accepted but dropped here so they never occupy a slot.
  assign w_lsu_wr = w_lsu_hs & (lsu_rd_i != 5'd0);
  assign w_alu_wr = alu_vld_i & (alu_rd_i != 5'd0);

  // The queue drains only in cycles the ALU leaves the write port free.
  assign w_pop  = ~w_alu_wr & ~w_fifo_empty;
  assign w_head = r_fifo[r_rptr];

`ifdef RV_WB_BYPASS_EN
  // Skip the FIFO only when it is empty, so ordering against older LSU results is kept.
  assign w_byp = ~w_alu_wr & w_fifo_empty & w_lsu_wr;
`else
  // No direct LSU-to-output path: every LSU write is staged in the FIFO.
  assign w_byp = 1'b0;
`endif

  assign w_push = w_lsu_wr & ~w_byp;

  // FIFO storage: write the tail on push; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= '{rd: lsu_rd_i, data: lsu_data_i};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: ALU first, then the oldest queued LSU result, then the bypass; hold address/data when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_reg  <= 5'd0;
      r_wr_data <= 64'd0;
    end else begin
      r_wr_en <= w_alu_wr | w_pop | w_byp;
      if (w_alu_wr) begin
        r_wr_reg  <= alu_rd_i;
        r_wr_data <= alu_data_i;
      end else if (w_pop) begin
        r_wr_reg  <= w_head.rd;
        r_wr_data <= w_head.data;
      end else if (w_byp) begin
        r_wr_reg  <= lsu_rd_i;
        r_wr_data <= lsu_data_i;
      end
    end
  end

  // Pending bitmap: OR of one-hot rd over occupied slots, walking from the head for count entries.
  always_comb begin
    w_pend_vec = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        w_pend_vec[r_fifo[r_rptr + AW'(i)].rd] = 1'b1;
      end
    end
  end

  assign wr_en_o    = r_wr_en;
  assign wr_reg_o   = r_wr_reg;
  assign wr_data_o  = r_wr_data;
  assign pend_vec_o = w_pend_vec;

endmodule

// File: tb/tb_rv_wb_arb.sv
// Testbench for rv_wb_arb: directed scenarios plus randomized traffic against a queue-based model.
module tb_rv_wb_arb;

  localparam int DEPTH = 2;
`ifdef RV_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_vld;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_vld;
  logic        lsu_rdy;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [63:0] wr_data;
  logic [31:0] pend_vec;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rv_wb_arb #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_vld_i  (alu_vld),
    .alu_rd_i   (alu_rd),
    .alu_data_i (alu_data),
    .lsu_vld_i  (lsu_vld),
    .lsu_rdy_o  (lsu_rdy),
    .lsu_rd_i   (lsu_rd),
    .lsu_data_i (lsu_data),
    .wr_en_o    (wr_en),
    .wr_reg_o   (wr_reg),
    .wr_data_o  (wr_data),
    .pend_vec_o (pend_vec)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic        m_en;
  logic [4:0]  m_reg;
  logic [63:0] m_data;

  function automatic void model_reset();
    m_q.delete();
    m_en   = 1'b0;
    m_reg  = 5'd0;
    m_data = 64'd0;
  endfunction

  function automatic logic model_rdy();
    return m_q.size() < DEPTH;
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] v = 32'd0;
    foreach (m_q[k]) v[m_q[k].rd] = 1'b1;
    return v;
  endfunction

  // One clock edge of behaviour: who gets the write port, and what joins the queue.
  function automatic void model_step(logic av, logic [4:0] ard, logic [63:0] adat,
                                     logic lv, logic [4:0] lrd, logic [63:0] ldat);
    logic taken;
    logic lsu_res;
    ent_t e;
    lsu_res = lv && model_rdy() && (lrd != 5'd0);
    taken   = 1'b0;
    m_en    = 1'b0;
    if (av && ard != 5'd0) begin
      m_en = 1'b1; m_reg = ard; m_data = adat;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_en = 1'b1; m_reg = e.rd; m_data = e.data;
    end else if (BYP && lsu_res) begin
      m_en = 1'b1; m_reg = lrd; m_data = ldat; taken = 1'b1;
    end
    if (lsu_res && !taken) begin
      e.rd = lrd; e.data = ldat;
      m_q.push_back(e);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_vld = 1'b0; alu_rd = 5'd0; alu_data = 64'd0;
    lsu_vld = 1'b0; lsu_rd = 5'd0; lsu_data = 64'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    lsu_vld = 1'b1; lsu_rd = 5'd3; lsu_data = 64'h55;
    alu_vld = 1'b1; alu_rd = 5'd4; alu_data = 64'h66;
    cyc(); cyc();
    n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else n_pass++;
    n_total++; if (lsu_rdy !== 1'b1) $display("FAIL reset_lsu_rdy got %b want 1", lsu_rdy); else n_pass++;
    n_total++; if (pend_vec !== 32'd0) $display("FAIL reset_pend got %h want 0", pend_vec); else n_pass++;
    n_total++; if (wr_reg !== 5'd0 || wr_data !== 64'd0)
      $display("FAIL reset_wr_reg_data got %0d/%h want 0/0", wr_reg, wr_data); else n_pass++;
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_total++; if (wr_en !== 1'b0) $display("FAIL reset_idle_wr_en cyc%0d got %b want 0", i, wr_en); else n_pass++;
    end
  endtask

  task automatic test_alu_priority();
    apply_reset();
    alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 64'h11;
    lsu_vld = 1'b1; lsu_rd = 5'd6; lsu_data = 64'h22;
    cyc();
    idle_inputs();
    n_total++; if (wr_en !== 1'b1 || wr_reg !== 5'd5 || wr_data !== 64'h11)
      $display("FAIL prio_alu_write got %b x%0d %h want 1 x5 11", wr_en, wr_reg, wr_data); else n_pass++;
    n_total++; if (pend_vec !== 32'h40) $display("FAIL prio_pend_set got %h want 00000040", pend_vec); else n_pass++;
    cyc();
    n_total++; if (wr_en !== 1'b1 || wr_reg !== 5'd6 || wr_data !== 64'h22)
      $display("FAIL prio_lsu_write got %b x%0d %h want 1 x6 22", wr_en, wr_reg, wr_data); else n_pass++;
    n_total++; if (pend_vec !== 32'd0) $display("FAIL prio_pend_clear got %h want 0", pend_vec); else n_pass++;
    cyc();
    n_total++; if (wr_en !== 1'b0) $display("FAIL prio_idle got %b want 0", wr_en); else n_pass++;
  endtask

  task automatic test_fifo_full();
    logic [4:0]  lrd_tab [7];
    logic        alu_tab [7];
    logic        rdy_tab [7];
    logic        en_tab  [7];
    logic [4:0]  reg_tab [7];
    lrd_tab = '{5'd7, 5'd8, 5'd9, 5'd9, 5'd9, 5'd9, 5'd0};
    alu_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rdy_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    en_tab  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    reg_tab = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8, 5'd9};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      alu_vld  = alu_tab[c]; alu_rd = alu_tab[c] ? 5'(c + 1) : 5'd0; alu_data = 64'(c + 'h100);
      lsu_vld  = (lrd_tab[c] != 5'd0); lsu_rd = lrd_tab[c]; lsu_data = 64'(lrd_tab[c]) << 4;
      #1;
      n_total++; if (lsu_rdy !== rdy_tab[c]) $display("FAIL full_rdy cyc%0d got %b want %b", c, lsu_rdy, rdy_tab[c]); else n_pass++;
      if (c == 2 || c == 3) begin
        n_total++; if (pend_vec !== 32'h180) $display("FAIL full_pend cyc%0d got %h want 00000180", c, pend_vec); else n_pass++;
      end
      cyc();
      n_total++; if (wr_en !== en_tab[c] || wr_reg !== reg_tab[c])
        $display("FAIL full_write cyc%0d got %b x%0d want %b x%0d", c, wr_en, wr_reg, en_tab[c], reg_tab[c]); else n_pass++;
    end
    idle_inputs();
    cyc();
    n_total++; if (wr_en !== 1'b0 || pend_vec !== 32'd0)
      $display("FAIL full_drained got en=%b pend=%h want 0/0", wr_en, pend_vec); else n_pass++;
  endtask

  task automatic test_x0_filter();
    apply_reset();
    alu_vld = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    cyc();
    n_total++; if (wr_en !== 1'b0) $display("FAIL x0_alu got %b want 0", wr_en); else n_pass++;
    idle_inputs();
    lsu_vld = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hBEEF;
    cyc();
    idle_inputs();
    n_total++; if (wr_en !== 1'b0) $display("FAIL x0_lsu got %b want 0", wr_en); else n_pass++;
    n_total++; if (dut.r_count !== '0) $display("FAIL x0_count got %0d want 0", dut.r_count); else n_pass++;
    cyc();
    n_total++; if (wr_en !== 1'b0 || lsu_rdy !== 1'b1 || pend_vec !== 32'd0)
      $display("FAIL x0_after got en=%b rdy=%b pend=%h want 0/1/0", wr_en, lsu_rdy, pend_vec); else n_pass++;
  endtask

  task automatic test_bypass();
    apply_reset();
    lsu_vld = 1'b1; lsu_rd = 5'd10; lsu_data = 64'h1234_5678_9ABC_DEF0;
    cyc();
    idle_inputs();
    n_total++; if (wr_en !== BYP) $display("FAIL byp_cyc1_en got %b want %b", wr_en, BYP); else n_pass++;
    n_total++; if (pend_vec !== (BYP ? 32'd0 : 32'h400))
      $display("FAIL byp_cyc1_pend got %h want %h", pend_vec, (BYP ? 32'd0 : 32'h400)); else n_pass++;
    cyc();
    n_total++; if (wr_en !== !BYP) $display("FAIL byp_cyc2_en got %b want %b", wr_en, !BYP); else n_pass++;
    n_total++; if (wr_reg !== 5'd10 || wr_data !== 64'h1234_5678_9ABC_DEF0)
      $display("FAIL byp_data got x%0d %h want x10 123456789abcdef0", wr_reg, wr_data); else n_pass++;
  endtask

  task automatic test_mid_drain_reset();
    apply_reset();
    alu_vld = 1'b1; alu_rd = 5'd1; alu_data = 64'hA1;
    lsu_vld = 1'b1; lsu_rd = 5'd11; lsu_data = 64'hB11;
    cyc();
    alu_rd = 5'd2; lsu_rd = 5'd12; lsu_data = 64'hB12;
    cyc();
    n_total++; if (pend_vec !== 32'h1800) $display("FAIL mdr_queued got %h want 00001800", pend_vec); else n_pass++;
    alu_vld = 1'b0; lsu_vld = 1'b1; lsu_rd = 5'd13;
    rst_n = 1'b0;
    #1;
    n_total++; if (wr_en !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 64'd0)
      $display("FAIL mdr_out_clear got %b x%0d %h want 0 x0 0", wr_en, wr_reg, wr_data); else n_pass++;
    n_total++; if (pend_vec !== 32'd0 || lsu_rdy !== 1'b1)
      $display("FAIL mdr_state_clear got pend=%h rdy=%b want 0/1", pend_vec, lsu_rdy); else n_pass++;
    cyc();
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_total++; if (wr_en !== 1'b0) $display("FAIL mdr_stale cyc%0d got %b want 0", i, wr_en); else n_pass++;
    end
    lsu_vld = 1'b1; lsu_rd = 5'd13; lsu_data = 64'hC13;
    cyc();
    idle_inputs();
    n_total++; if (wr_en !== BYP) $display("FAIL mdr_next_cyc1 got %b want %b", wr_en, BYP); else n_pass++;
    cyc();
    n_total++; if (wr_en !== !BYP || wr_reg !== 5'd13 || wr_data !== 64'hC13)
      $display("FAIL mdr_next_cyc2 got %b x%0d %h want %b x13 c13", wr_en, wr_reg, wr_data, !BYP); else n_pass++;
    model_reset();
  endtask

  task automatic test_random();
    int alu_pct;
    logic [31:0] mp;
    int errs = 0;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        model_reset();
      end
      case ((c / 100) % 4)
        0: alu_pct = 20;
        1: alu_pct = 90;
        2: alu_pct = 50;
        default: alu_pct = 0;
      endcase
      mp       = model_pend();
      lsu_vld  = ($urandom_range(0, 99) < 60);
      lsu_rd   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lsu_data = {$urandom, $urandom};
      alu_vld  = ($urandom_range(0, 99) < alu_pct);
      alu_rd   = 5'($urandom_range(0, 31));
      alu_data = {$urandom, $urandom};
      if (mp[alu_rd] || (lsu_vld && alu_rd == lsu_rd)) alu_rd = 5'd0;
      #1;
      n_total++;
      if (lsu_rdy !== model_rdy()) begin
        if (errs < 10) $display("FAIL rand_rdy cyc%0d got %b want %b", c, lsu_rdy, model_rdy());
        errs++;
      end else n_pass++;
      model_step(alu_vld, alu_rd, alu_data, lsu_vld, lsu_rd, lsu_data);
      cyc();
      n_total++;
      if (wr_en !== m_en || wr_reg !== m_reg || wr_data !== m_data || pend_vec !== model_pend()) begin
        if (errs < 10)
          $display("FAIL rand_out cyc%0d got %b x%0d %h pend=%h want %b x%0d %h pend=%h",
                   c, wr_en, wr_reg, wr_data, pend_vec, m_en, m_reg, m_data, model_pend());
        errs++;
      end else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_alu_priority();
    test_fifo_full();
    test_x0_filter();
    test_bypass();
    test_mid_drain_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
